// File: rtl/gift_keysched_seq.sv
// gift_keysched_seq -- sequential GIFT-64 / GIFT-128 round-key generator.
//
// Produces one round key per handshake (rkValid && rkReady) from a 128-bit
// master key, together with the 6-bit round constant and the round index.
// The first key is valid the cycle after start; outputs hold while stalled.
//
// Parameters:
//   BLOCK_BITS   64 (GIFT-64, 28 rounds) or 128 (GIFT-128, 40 rounds)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   load keyIn and begin a schedule (IDLE only)
//   keyIn      in   128-bit master key, k7 = keyIn[127:112] ... k0 = keyIn[15:0]
//   rkReady    in   consumer accepts the current round key
//   rkValid    out  rk/rc/round hold a valid round key
//   rk         out  round key {U,V}, BLOCK_BITS/2 bits
//   rc         out  round constant paired with rk
//   round      out  index of the current round key
//   busy       out  schedule in progress (RUN or DONE)
//   done       out  one-cycle pulse after the last round key is accepted
//   keyFinal   out  key register (only with GIFT_KS_FINALKEY_EN defined)
//
// Build option:
//   GIFT_KS_FINALKEY_EN  adds keyFinal, the key state after all updates,
//                        usable as the seed of an inverse schedule.

module gift_keysched_seq #(
    parameter int unsigned BLOCK_BITS = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [127:0]              keyIn,
    input  logic                      rkReady,
    output logic                      rkValid,
    output logic [BLOCK_BITS/2-1:0]   rk,
    output logic [5:0]                rc,
    output logic [5:0]                round,
    output logic                      busy,
`ifdef GIFT_KS_FINALKEY_EN
    output logic [127:0]              keyFinal,
`endif
    output logic                      done
);

    localparam int unsigned ROUNDS = (BLOCK_BITS == 64) ? 28 : 40;

    // Reject unsupported cipher variants at elaboration.
    generate
        if (BLOCK_BITS != 64 && BLOCK_BITS != 128) begin : g_bad_block_bits
            $error("gift_keysched_seq: BLOCK_BITS must be 64 or 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic [127:0] key_q;
    logic [5:0]   lfsr_q;
    logic [5:0]   round_q;

    logic         load_c;
    logic         hs_c;
    logic         last_c;
    logic [127:0] key_next_c;
    logic [5:0]   lfsr_next_c;

    // Final round key of the run is being presented.
    assign last_c = (round_q == 6'(ROUNDS - 1));

    // Key state update: k7 <= k1 >>> 2, k6 <= k0 >>> 12, k5..k0 <= k7..k2.
    assign key_next_c = {key_q[17:16], key_q[31:18],
                         key_q[11:0],  key_q[15:12],
                         key_q[127:32]};

    // Round-constant LFSR: shift left, feedback c5 ^ c4 ^ 1.
    assign lfsr_next_c = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4] ^ 1'b1};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rkReady && last_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs and datapath strobes.
    always_comb begin
        rkValid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        load_c  = 1'b0;
        hs_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_c = start;
            end
            S_RUN: begin
                rkValid = 1'b1;
                busy    = 1'b1;
                hs_c    = rkReady;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                rkValid = 1'b0;
            end
        endcase
    end

    // Key, LFSR and round-index registers; only move on load or handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q   <= '0;
            lfsr_q  <= '0;
            round_q <= '0;
        end else if (load_c) begin
            key_q   <= keyIn;
            lfsr_q  <= 6'h01;
            round_q <= '0;
        end else if (hs_c) begin
            key_q  <= key_next_c;
            lfsr_q <= lfsr_next_c;
            // Index stays on the last round so it remains meaningful after DONE.
            if (!last_c) begin
                round_q <= round_q + 6'd1;
            end
        end
    end

    // Round key extraction: U = k5||k4, V = k1||k0 (128); U = k1, V = k0 (64).
    generate
        if (BLOCK_BITS == 128) begin : g_rk128
            assign rk = {key_q[95:64], key_q[31:0]};
        end else begin : g_rk64
            assign rk = key_q[BLOCK_BITS/2-1:0];
        end
    endgenerate

    assign rc    = lfsr_q;
    assign round = round_q;

`ifdef GIFT_KS_FINALKEY_EN
    assign keyFinal = key_q;
`endif

endmodule

// File: tb/tb_gift_keysched_seq.sv
// Directed bench for gift_keysched_seq: a GIFT-128 and a GIFT-64 instance,
// checked against hand-derived vectors, a tabulated round-constant sequence
// and a word-level key-state model.

module tb_gift_keysched_seq;

    localparam logic [127:0] KVEC = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KB   = 128'hFEDCBA9876543210_0123456789ABCDEF;

    localparam logic [5:0] RC_TAB [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
    };

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // GIFT-128 instance signals
    logic         a_rst, a_start, a_rdy, a_valid, a_busy, a_done;
    logic [127:0] a_key;
    logic [63:0]  a_rk;
    logic [5:0]   a_rc, a_round;
    // GIFT-64 instance signals
    logic         b_rst, b_start, b_rdy, b_valid, b_busy, b_done;
    logic [127:0] b_key;
    logic [31:0]  b_rk;
    logic [5:0]   b_rc, b_round;
`ifdef GIFT_KS_FINALKEY_EN
    logic [127:0] a_kf, b_kf;
`endif

    gift_keysched_seq #(.BLOCK_BITS(128)) u_dut128 (
        .clk(clk), .rst_n(a_rst), .start(a_start), .keyIn(a_key),
        .rkReady(a_rdy), .rkValid(a_valid), .rk(a_rk), .rc(a_rc),
        .round(a_round), .busy(a_busy),
`ifdef GIFT_KS_FINALKEY_EN
        .keyFinal(a_kf),
`endif
        .done(a_done)
    );

    gift_keysched_seq #(.BLOCK_BITS(64)) u_dut64 (
        .clk(clk), .rst_n(b_rst), .start(b_start), .keyIn(b_key),
        .rkReady(b_rdy), .rkValid(b_valid), .rk(b_rk), .rc(b_rc),
        .round(b_round), .busy(b_busy),
`ifdef GIFT_KS_FINALKEY_EN
        .keyFinal(b_kf),
`endif
        .done(b_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int a_hs = 0, a_dn = 0, b_hs = 0, b_dn = 0;

    // Handshake and done-pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_valid && a_rdy) a_hs++;
        if (a_done)           a_dn++;
        if (b_valid && b_rdy) b_hs++;
        if (b_done)           b_dn++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    // Word-level key-state update.
    function automatic logic [127:0] ks_next(input logic [127:0] k);
        logic [15:0] w [8];
        logic [15:0] n [8];
        logic [127:0] r;
        for (int j = 0; j < 8; j++) w[j] = k[16*j +: 16];
        n[7] = rotr16(w[1], 2);
        n[6] = rotr16(w[0], 12);
        for (int j = 0; j < 6; j++) n[j] = w[j+2];
        for (int j = 0; j < 8; j++) r[16*j +: 16] = n[j];
        return r;
    endfunction

    function automatic logic [15:0] kw(input logic [127:0] k, input int j);
        return k[16*j +: 16];
    endfunction

    // GIFT-128 schedule run with optional stall, ignored start and abort.
    task automatic run_a(input logic [127:0] key, input int stall_rd,
                         input int inj_rd, input int rst_rd);
        logic [127:0] km;
        logic [63:0]  exp_rk;
        int hs0, dn0;
        km = key; hs0 = a_hs; dn0 = a_dn;
        a_key = key; a_start = 1'b1; a_rdy = 1'b1;
        step();
        a_start = 1'b0;
        for (int r = 0; r < 40; r++) begin
            exp_rk = {kw(km, 5), kw(km, 4), kw(km, 1), kw(km, 0)};
            check("a_valid", 128'(a_valid), 128'(1'b1));
            check("a_rk",    128'(a_rk),    128'(exp_rk));
            check("a_rc",    128'(a_rc),    128'(RC_TAB[r]));
            check("a_round", 128'(a_round), 128'(r));
            if (key == KVEC && r == 0) check("a_rk_r0", 128'(a_rk), 128'(64'h040506070C0D0E0F));
            if (key == KVEC && r == 1) check("a_rk_r1", 128'(a_rk), 128'(64'h0001020308090A0B));
            if (r == stall_rd) begin
                a_rdy = 1'b0;
                repeat (3) begin
                    step();
                    check("a_stall_valid", 128'(a_valid), 128'(1'b1));
                    check("a_stall_rk",    128'(a_rk),    128'(exp_rk));
                    check("a_stall_rc",    128'(a_rc),    128'(RC_TAB[r]));
                    check("a_stall_round", 128'(a_round), 128'(r));
                end
                a_rdy = 1'b1;
            end
            if (r == inj_rd) begin
                a_start = 1'b1;
                a_key   = ~key;
            end
            if (r == rst_rd) a_rst = 1'b0;
            step();
            a_start = 1'b0;
            if (r == rst_rd) begin
                check("a_abort_valid", 128'(a_valid), 128'(1'b0));
                check("a_abort_busy",  128'(a_busy),  128'(1'b0));
                check("a_abort_done",  128'(a_done),  128'(1'b0));
                check("a_abort_rk",    128'(a_rk),    128'(0));
                check("a_abort_rc",    128'(a_rc),    128'(0));
                check("a_abort_round", 128'(a_round), 128'(0));
                a_rst = 1'b1;
                step();
                check("a_abort_busy2", 128'(a_busy), 128'(1'b0));
                check("a_abort_dcnt",  128'(a_dn - dn0), 128'(0));
                return;
            end
            km = ks_next(km);
        end
        check("a_done",       128'(a_done),  128'(1'b1));
        check("a_done_valid", 128'(a_valid), 128'(1'b0));
        check("a_done_busy",  128'(a_busy),  128'(1'b1));
        check("a_done_round", 128'(a_round), 128'(39));
        check("a_done_rc",    128'(a_rc),    128'(6'h34));
`ifdef GIFT_KS_FINALKEY_EN
        check("a_keyfinal", a_kf, km);
        if (key == '0) check("a_keyfinal_zero", a_kf, 128'h0);
`endif
        step();
        check("a_idle_done",  128'(a_done),  128'(1'b0));
        check("a_idle_busy",  128'(a_busy),  128'(1'b0));
        check("a_idle_valid", 128'(a_valid), 128'(1'b0));
        check("a_hs_count",   128'(a_hs - hs0), 128'(40));
        check("a_done_count", 128'(a_dn - dn0), 128'(1));
    endtask

    // GIFT-64 full schedule run.
    task automatic run_b(input logic [127:0] key);
        logic [127:0] km;
        logic [31:0]  exp_rk;
        int hs0, dn0;
        km = key; hs0 = b_hs; dn0 = b_dn;
        b_key = key; b_start = 1'b1; b_rdy = 1'b1;
        step();
        b_start = 1'b0;
        for (int r = 0; r < 28; r++) begin
            exp_rk = {kw(km, 1), kw(km, 0)};
            check("b_valid", 128'(b_valid), 128'(1'b1));
            check("b_rk",    128'(b_rk),    128'(exp_rk));
            check("b_rc",    128'(b_rc),    128'(RC_TAB[r]));
            check("b_round", 128'(b_round), 128'(r));
            if (key == KVEC && r == 0)  check("b_rk_r0", 128'(b_rk), 128'(32'h0C0D0E0F));
            if (key == KVEC && r == 1)  check("b_rk_r1", 128'(b_rk), 128'(32'h08090A0B));
            if (r == 27)                check("b_rc_last", 128'(b_rc), 128'(6'h0B));
            step();
            km = ks_next(km);
        end
        check("b_done",       128'(b_done),  128'(1'b1));
        check("b_done_valid", 128'(b_valid), 128'(1'b0));
        check("b_done_round", 128'(b_round), 128'(27));
        check("b_done_rc",    128'(b_rc),    128'(6'h17));
`ifdef GIFT_KS_FINALKEY_EN
        check("b_keyfinal", b_kf, km);
`endif
        step();
        check("b_idle_busy",  128'(b_busy),  128'(1'b0));
        check("b_idle_done",  128'(b_done),  128'(1'b0));
        check("b_hs_count",   128'(b_hs - hs0), 128'(28));
        check("b_done_count", 128'(b_dn - dn0), 128'(1));
    endtask

    initial begin
        // Reset with start asserted: reset must win.
        a_rst = 1'b0; a_start = 1'b1; a_rdy = 1'b0; a_key = KVEC;
        b_rst = 1'b0; b_start = 1'b1; b_rdy = 1'b0; b_key = KVEC;
        step();
        step();
        check("rst_valid", 128'(a_valid), 128'(1'b0));
        check("rst_busy",  128'(a_busy),  128'(1'b0));
        check("rst_done",  128'(a_done),  128'(1'b0));
        check("rst_rk",    128'(a_rk),    128'(0));
        check("rst_rc",    128'(a_rc),    128'(0));
        check("rst_round", 128'(a_round), 128'(0));
        check("rst_b_valid", 128'(b_valid), 128'(1'b0));
`ifdef GIFT_KS_FINALKEY_EN
        check("rst_keyfinal", a_kf, 128'h0);
`endif
        a_start = 1'b0; b_start = 1'b0;
        a_rst = 1'b1;   b_rst = 1'b1;
        step();
        check("idle_no_start", 128'(a_busy), 128'(1'b0));

        run_a(KVEC, -1, -1, -1);
        run_a(KVEC, 5, 10, 12);
        run_a(KB, -1, 39, -1);
        run_a(128'h0, -1, -1, -1);
        run_b(KVEC);
        run_b(KB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gift_keysched_seq.md
GIFT_KEYSCHED_SEQ -- requirements
Module: gift_keysched_seq

Interface
REQ-001 SHALL provide parameter BLOCK_BITS, default 128, cipher variant: 64 (GIFT-64, 28 rounds) or 128 (GIFT-128, 40 rounds); any other value is a compile-time error.
REQ-002 SHALL derive RK_BITS = BLOCK_BITS/2 (32 or 64) and ROUNDS = 28 or 40 from BLOCK_BITS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  load keyIn and begin a schedule run; honoured only in IDLE.
REQ-006 keyIn  input  128  master key, k7 = keyIn[127:112] ... k0 = keyIn[15:0].
REQ-007 rkReady  input  1  consumer accepts current round key.
REQ-008 rkValid  output  1  rk/rc/round hold a valid round key.
REQ-009 rk  output  RK_BITS  round key {U,V}: GIFT-128 U=k5||k4, V=k1||k0; GIFT-64 U=k1, V=k0.
REQ-010 rc  output  6  round constant paired with rk.
REQ-011 round  output  6  index of current round key, 0..ROUNDS-1.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse after last round key accepted.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE.
REQ-015 IDLE: start=1 -> key register <= keyIn, lfsr <= 6'h01, round <= 0, go RUN; start=0 -> stay.
REQ-016 RUN: rkValid=1; rk, rc, round driven combinationally from registers; no added latency, first key valid the cycle after start.
REQ-017 Handshake: key advances only on rkValid && rkReady; with rkReady=0 all outputs SHALL hold stable for any number of cycles.
REQ-018 Key update on handshake: {k7..k0} <= {k1>>>2, k0>>>12, k7, k6, k5, k4, k3, k2} (16-bit rotates right).
REQ-019 LFSR update on handshake: {c5..c0} <= {c4,c3,c2,c1,c0, c5^c4^1}; sequence 01,03,07,0F,1F,3E,3D,...
REQ-020 Handshake with round == ROUNDS-1 -> DONE; otherwise round <= round+1, stay RUN.
REQ-021 DONE: done=1, rkValid=0 for exactly one cycle, then IDLE unconditionally.
REQ-022 start in RUN or DONE SHALL be ignored, including start coincident with the final handshake.
REQ-023 start in IDLE coincident with rst_n=0: reset wins.
REQ-024 Outside RUN, rk, rc and round SHALL hold their last register-derived values (not forced); consumers qualify with rkValid.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, key register 0, lfsr 0, round 0; thus rkValid=0, busy=0, done=0, rk=0, rc=0.
REQ-026 Reset mid-run SHALL abort without done pulse; next start begins a fresh schedule.

Configuration
REQ-027 Macro GIFT_KS_FINALKEY_EN defined: SHALL add output keyFinal[127:0] = key register, equal to key state after ROUNDS updates while done=1 (seed for inverse schedule); 0 after reset.
REQ-028 Macro undefined: keyFinal port and any logic for it SHALL be absent; all other behaviour identical.

Verification
REQ-029 BLOCK_BITS=128, keyIn=128'h000102030405060708090A0B0C0D0E0F, start, rkReady=1 -> round0 rk=64'h040506070C0D0E0F rc=6'h01; round1 rk=64'h0001020308090A0B rc=6'h03.
REQ-030 BLOCK_BITS=64, same key -> round0 rk=32'h0C0D0E0F rc=6'h01; round1 rk=32'h08090A0B rc=6'h03; 28th key rc=6'h0B; done one cycle after its handshake.
REQ-031 BLOCK_BITS=128, rkReady=1 continuous -> exactly 40 handshakes, 40th rc=6'h1A, round=39, done pulse 1 cycle, busy low next cycle.
REQ-032 rkReady=0 for 3 cycles at round 5 -> rk, rc, round unchanged across stall; round 6 appears only after rkReady returns high.
REQ-033 start pulsed at round 10 with different keyIn -> ignored, sequence unchanged; rst_n=0 at round 12 -> next cycle rkValid=0, busy=0, rk=0, no done pulse.
REQ-034 With GIFT_KS_FINALKEY_EN, all-zero key -> keyFinal=128'h0 at done; nonzero key -> keyFinal matches model after 40 updates.
